spi_cfg_tx: RTL

Serial configuration transmitter: the initiator end of the synth's 60-bit config shift link. Accepts one packed parameter set (ADSR, oscillator count, filter coefficients) via a valid/ready handshake and serialises it on `nss`/`mosi` in the same `clk` domain as the config receiver. After exactly 60 bits the receiver holds the new configuration. Used by on-chip preset/sequencer logic and by the testbench as the reference driver.

---
 rtl/spi_cfg_tx_pkg.sv | 54 +++++
 rtl/spi_cfg_tx.sv | 121 ++++++++++++
 2 files changed

// File: rtl/spi_cfg_tx_pkg.sv
// Shared frame layout and FSM states for the 60-bit config shift link (transmitter and receiver).
package spi_cfg_tx_pkg;

  localparam int FRAME_W = 60;

  localparam int ADSR_W       = 8;
  localparam int OSC_W        = 12;
  localparam int FILT_W       = 8;
  localparam int ADSR_AI_OFS  = 0;
  localparam int ADSR_DI_OFS  = 8;
  localparam int ADSR_S_OFS   = 16;
  localparam int ADSR_RI_OFS  = 24;
  localparam int OSC_OFS      = 32;
  localparam int FILT_A_OFS   = 44;
  localparam int FILT_B_OFS   = 52;

  // Declaration order places filter_b at the MSB end so the struct matches the offsets above.
  typedef struct packed {
    logic [FILT_W-1:0] filter_b;
    logic [FILT_W-1:0] filter_a;
    logic [OSC_W-1:0]  osc_count;
    logic [ADSR_W-1:0] adsr_ri;
    logic [ADSR_W-1:0] adsr_s;
    logic [ADSR_W-1:0] adsr_di;
    logic [ADSR_W-1:0] adsr_ai;
  } cfg_frame_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  function automatic cfg_frame_t pack_cfg(
    input logic [ADSR_W-1:0] ai,
    input logic [ADSR_W-1:0] di,
    input logic [ADSR_W-1:0] s,
    input logic [ADSR_W-1:0] ri,
    input logic [OSC_W-1:0]  osc,
    input logic [FILT_W-1:0] fa,
    input logic [FILT_W-1:0] fb
  );
    cfg_frame_t f;
    f.filter_b  = fb;
    f.filter_a  = fa;
    f.osc_count = osc;
    f.adsr_ri   = ri;
    f.adsr_s    = s;
    f.adsr_di   = di;
    f.adsr_ai   = ai;
    return f;
  endfunction

endpackage

// File: rtl/spi_cfg_tx.sv
// Config link initiator: packs one parameter set and shifts it out MSB first on nss/mosi; SPI_CFG_TX_AUTOLOAD_EN sends DEFAULT_CFG after reset.
// Latency: nss low and first bit on mosi right after the handshake edge, frame is exactly 60 cycles, done one cycle after the last bit.
// Backpressure: cfg_ready only in IDLE; no accept during a frame or the GAP_CYCLES gap, no skid buffer.
module spi_cfg_tx
  import spi_cfg_tx_pkg::*;
#(
  parameter int unsigned        GAP_CYCLES  = 2,
  parameter logic [FRAME_W-1:0] DEFAULT_CFG = '0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADSR_W-1:0] adsr_ai,
  input  logic [ADSR_W-1:0] adsr_di,
  input  logic [ADSR_W-1:0] adsr_s,
  input  logic [ADSR_W-1:0] adsr_ri,
  input  logic [OSC_W-1:0]  osc_count,
  input  logic [FILT_W-1:0] filter_a,
  input  logic [FILT_W-1:0] filter_b,
  output logic              nss,
  output logic              mosi,
  output logic              busy,
  output logic              done
);

`ifdef SPI_CFG_TX_AUTOLOAD_EN
  localparam logic PEND_RST = 1'b1;
`else
  localparam logic PEND_RST = 1'b0;
`endif

  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);
  localparam logic [5:0] BIT_LOAD = 6'(FRAME_W - 1);

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sr_q, sr_d;
  logic [5:0]         bit_q, bit_d;
  logic [3:0]         gap_q, gap_d;
  logic               pend_q, pend_d;
  logic               nss_d, mosi_d, busy_d, ready_d, done_d;
  cfg_frame_t         frame_in;

  assign frame_in = pack_cfg(adsr_ai, adsr_di, adsr_s, adsr_ri, osc_count, filter_a, filter_b);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= ST_IDLE;
      sr_q      <= '0;
      bit_q     <= '0;
      gap_q     <= '0;
      pend_q    <= PEND_RST;
      nss       <= 1'b1;
      mosi      <= 1'b0;
      busy      <= 1'b0;
      cfg_ready <= ~PEND_RST;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_q     <= bit_d;
      gap_q     <= gap_d;
      pend_q    <= pend_d;
      nss       <= nss_d;
      mosi      <= mosi_d;
      busy      <= busy_d;
      cfg_ready <= ready_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A pending autoload frame takes priority over (and blocks) any handshake.
        if (pend_q) begin
          sr_d    = DEFAULT_CFG;
          bit_d   = BIT_LOAD;
          pend_d  = 1'b0;
          state_d = ST_SHIFT;
        end else if (cfg_valid && cfg_ready) begin
          sr_d    = frame_in;
          bit_d   = BIT_LOAD;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sr_d = {sr_q[FRAME_W-2:0], 1'b0};
        if (bit_q == 6'd0) begin
          state_d = ST_GAP;
          gap_d   = GAP_LOAD;
          done_d  = 1'b1;
        end else begin
          bit_d = bit_q - 6'd1;
        end
      end
      ST_GAP: begin
        if (gap_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from next state so every port comes straight from a flop.
    nss_d   = (state_d != ST_SHIFT);
    mosi_d  = (state_d == ST_SHIFT) ? sr_d[FRAME_W-1] : 1'b0;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE) && !pend_d;
  end

endmodule
